// File: rtl/pic_pkg.sv
// Shared encodings for the 8259A command sequencer: state set, ICW/OCW bit
// positions, and the rules that pick the next expected initialisation word.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ICW2 = 3'd1,
    ST_WAIT_ICW3 = 3'd2,
    ST_WAIT_ICW4 = 3'd3,
    ST_READY     = 3'd4
  } pic_state_e;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_ID   = 4;
  localparam int OCW3_MARK = 3;
  localparam int ICW4_AEOI = 1;

  function automatic pic_state_e after_icw2(input logic [7:0] icw1);
    if (!icw1[ICW1_SNGL])    return ST_WAIT_ICW3;
    else if (icw1[ICW1_IC4]) return ST_WAIT_ICW4;
    else                     return ST_READY;
  endfunction

  function automatic pic_state_e after_icw3(input logic [7:0] icw1);
    return icw1[ICW1_IC4] ? ST_WAIT_ICW4 : ST_READY;
  endfunction

endpackage

// File: rtl/pic_write_handshake.sv
// Four-phase accept/ACK for bytes from the read/write logic: one accept pulse
// per request, with the byte and A0 presented alongside it.
module pic_write_handshake (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       write_flag_i,
  input  logic       a0_i,
  input  logic [7:0] data_i,
  output logic       accept_o,
  output logic       cmd_a0_o,
  output logic [7:0] cmd_data_o,
  output logic       ack_o
);

  logic ack_q;

  // Accept is combinational so the register update lands on the same edge as ACK.
  assign accept_o   = write_flag_i & ~ack_q;
  assign cmd_a0_o   = a0_i;
  assign cmd_data_o = data_i;
  assign ack_o      = ack_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q <= 1'b0;
    end else if (accept_o) begin
      ack_q <= 1'b1;
    end else if (!write_flag_i) begin
      ack_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pic_init_sequencer.sv
// Steers accepted command bytes into ICW1-4 / OCW1-3 following the 8259A
// initialisation sequence.
//   state        | meaning
//   ST_IDLE      | uninitialised, only ICW1 has effect
//   ST_WAIT_ICW2 | ICW1 seen, next A0=1 byte is ICW2
//   ST_WAIT_ICW3 | cascade mode, next A0=1 byte is ICW3
//   ST_WAIT_ICW4 | IC4 set, next A0=1 byte is ICW4
//   ST_READY     | initialised, A0=1 -> OCW1, A0=0 -> OCW2/OCW3
module pic_init_sequencer
  import pic_pkg::*;
#(
  parameter logic [7:0] IMR_RST  = 8'h00,
  parameter logic [7:0] OCW3_RST = 8'h0A
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       write_flag_i,
  input  logic       a0_i,
  input  logic [7:0] data_in_i,
  output logic       write_flag_ack_o,
  output logic [7:0] icw1_o,
  output logic [7:0] icw2_o,
  output logic [7:0] icw3_o,
  output logic [7:0] icw4_o,
  output logic [7:0] ocw1_o,
  output logic [7:0] ocw2_o,
  output logic [7:0] ocw3_o,
  output logic       ocw2_strobe_o,
  output logic       init_done_o,
  output logic [4:0] vector_base_o,
  output logic       single_mode_o,
  output logic       auto_eoi_o
);

  pic_state_e state_q, state_d;
  logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
  logic [7:0] ocw1_q, ocw1_d, ocw2_q, ocw2_d, ocw3_q, ocw3_d;
  logic       strobe_q, strobe_d;
  logic       accept, cmd_a0;
  logic [7:0] cmd_data;

  pic_write_handshake u_hs (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .write_flag_i (write_flag_i),
    .a0_i         (a0_i),
    .data_i       (data_in_i),
    .accept_o     (accept),
    .cmd_a0_o     (cmd_a0),
    .cmd_data_o   (cmd_data),
    .ack_o        (write_flag_ack_o)
  );

  always_comb begin
    state_d  = state_q;
    icw1_d   = icw1_q;
    icw2_d   = icw2_q;
    icw3_d   = icw3_q;
    icw4_d   = icw4_q;
    ocw1_d   = ocw1_q;
    ocw2_d   = ocw2_q;
    ocw3_d   = ocw3_q;
    strobe_d = 1'b0;
    if (accept) begin
      if (!cmd_a0 && cmd_data[ICW1_ID]) begin
        icw1_d  = cmd_data;
        icw2_d  = 8'h00;
        icw3_d  = 8'h00;
        icw4_d  = 8'h00;
        ocw1_d  = IMR_RST;
        ocw3_d  = OCW3_RST;
        state_d = ST_WAIT_ICW2;
      end else begin
        case (state_q)
          ST_WAIT_ICW2: if (cmd_a0) begin
            icw2_d  = cmd_data;
            state_d = after_icw2(icw1_q);
          end
          ST_WAIT_ICW3: if (cmd_a0) begin
            icw3_d  = cmd_data;
            state_d = after_icw3(icw1_q);
          end
          ST_WAIT_ICW4: if (cmd_a0) begin
            icw4_d  = cmd_data;
            state_d = ST_READY;
          end
          ST_READY: begin
            if (cmd_a0)                  ocw1_d = cmd_data;
            else if (cmd_data[OCW3_MARK]) ocw3_d = cmd_data;
            else begin
              ocw2_d   = cmd_data;
              strobe_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      icw1_q   <= 8'h00;
      icw2_q   <= 8'h00;
      icw3_q   <= 8'h00;
      icw4_q   <= 8'h00;
      ocw1_q   <= IMR_RST;
      ocw2_q   <= 8'h00;
      ocw3_q   <= OCW3_RST;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      icw1_q   <= icw1_d;
      icw2_q   <= icw2_d;
      icw3_q   <= icw3_d;
      icw4_q   <= icw4_d;
      ocw1_q   <= ocw1_d;
      ocw2_q   <= ocw2_d;
      ocw3_q   <= ocw3_d;
      strobe_q <= strobe_d;
    end
  end

  assign icw1_o        = icw1_q;
  assign icw2_o        = icw2_q;
  assign icw3_o        = icw3_q;
  assign icw4_o        = icw4_q;
  assign ocw1_o        = ocw1_q;
  assign ocw2_o        = ocw2_q;
  assign ocw3_o        = ocw3_q;
  assign ocw2_strobe_o = strobe_q;
  assign init_done_o   = (state_q == ST_READY);
  assign vector_base_o = icw2_q[7:3];
  assign single_mode_o = icw1_q[ICW1_SNGL];
  assign auto_eoi_o    = icw4_q[ICW4_AEOI];

endmodule
